// File: rtl/switch_pkg.sv
// Shared types and header helpers for the switch port receive path.
package switch_pkg;

  typedef enum logic [1:0] {
    PT_SINGLE    = 2'd0,
    PT_MULTICAST = 2'd1,
    PT_BROADCAST = 2'd2
  } ptype_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_SRC_ONEHOT = 3'd1,
    ERR_TGT_MISS   = 3'd2,
    ERR_OVERLAP    = 3'd3,
    ERR_LEN        = 3'd4,
    ERR_TRUNC      = 3'd5,
    ERR_OVERFLOW   = 3'd6
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAY,
    ST_DROP
  } rx_state_e;

  typedef struct packed {
    logic       eop;
    logic [7:0] data;
  } fifo_entry_t;

  function automatic logic [2:0] countones(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic ptype_e classify_ptype(input logic [3:0] tgt);
    if (tgt == 4'hf)              return PT_BROADCAST;
    else if (countones(tgt) == 3'd1) return PT_SINGLE;
    else                          return PT_MULTICAST;
  endfunction

  // Earliest failing check wins.
  function automatic err_code_e check_header(input logic [7:0] hdr, input logic [1:0] port);
    logic [3:0] src;
    logic [3:0] tgt;
    src = hdr[7:4];
    tgt = hdr[3:0];
    if (countones(src) != 3'd1)                    return ERR_SRC_ONEHOT;
    else if (!tgt[port])                           return ERR_TGT_MISS;
    else if (tgt != 4'hf && (src & tgt) != 4'h0)   return ERR_OVERLAP;
    else                                           return ERR_NONE;
  endfunction

endpackage

// File: rtl/switch_port_rx_if.sv
// Byte stream in from the switch output plus committed-packet stream out.
interface switch_port_rx_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       suspend_o;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic [1:0] out_ptype;

  modport slave (
    input  in_valid, in_data, out_ready,
    output suspend_o, out_valid, out_data, out_sop, out_eop, out_ptype
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  suspend_o, out_valid, out_data, out_sop, out_eop, out_ptype
  );
endinterface

// File: rtl/switch_rx_fifo.sv
// Store-and-forward FIFO: writes stay invisible to the reader until committed,
// and can be discarded back to the last commit point.
module switch_rx_fifo
  import switch_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  fifo_entry_t   wr_entry,
  input  logic          commit,
  input  logic          rollback,
  input  logic          rd_en,
  output fifo_entry_t   rd_entry,
  output logic          rd_valid,
  output logic          full,
  output logic [PW-1:0] free
);

  fifo_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, commit_ptr_q, rd_ptr_q;
  logic [PW-1:0] wr_ptr_d, commit_ptr_d, rd_ptr_d;
  logic [PW-1:0] used;

  assign used     = wr_ptr_q - rd_ptr_q;
  assign full     = (used == PW'(DEPTH));
  assign free     = PW'(DEPTH) - used;
  assign rd_valid = (rd_ptr_q != commit_ptr_q);
  assign rd_entry = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  // Commit includes a write happening in the same cycle (the eop byte).
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    if (rollback)   wr_ptr_d = commit_ptr_q;
    else if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (commit)     commit_ptr_d = wr_ptr_q + PW'(wr_en);
    if (rd_en)      rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/switch_port_rx.sv
// Receive endpoint for one switch output port: header/length checking,
// store-and-forward buffering and valid/ready packet release.
module switch_port_rx
  import switch_pkg::*;
#(
  parameter int unsigned PORT_ID        = 0,
  parameter int unsigned FIFO_DEPTH     = 64,
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned SUSPEND_MARGIN = 4
) (
  input  logic             clk,
  input  logic             reset,
  switch_port_rx_if.slave  port,
  output logic             err_pulse,
  output logic [2:0]       err_code,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      err_cnt
);

  localparam int unsigned   PW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0]    PortSel = 2'(PORT_ID);
  localparam logic [7:0]    MaxLenB = 8'(MAX_LEN);
  localparam logic [PW-1:0] Margin  = PW'(SUSPEND_MARGIN);

  rx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_pulse_q, err_pulse_d;
  err_code_e   err_code_q, err_d, hdr_err;
  logic [15:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic        suspend_q, suspend_d;
  logic        sop_q, sop_d;

  logic          wr_en, commit, rollback, rd_en, rd_valid, full;
  fifo_entry_t   wr_entry, rd_entry;
  logic [PW-1:0] free;

  switch_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_entry (wr_entry),
    .commit   (commit),
    .rollback (rollback),
    .rd_en    (rd_en),
    .rd_entry (rd_entry),
    .rd_valid (rd_valid),
    .full     (full),
    .free     (free)
  );

  assign hdr_err = check_header(port.in_data, PortSel);

  // Every error path shares one rollback/pulse epilogue after the state decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_entry = '{eop: 1'b0, data: port.in_data};
    commit   = 1'b0;
    rollback = 1'b0;
    err_d    = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (port.in_valid) begin
          if (full)                     err_d = ERR_OVERFLOW;
          else if (hdr_err != ERR_NONE) err_d = hdr_err;
          else begin
            wr_en   = 1'b1;
            state_d = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (!port.in_valid)                                  err_d = ERR_TRUNC;
        else if (port.in_data == 8'd0 || port.in_data > MaxLenB) err_d = ERR_LEN;
        else if (full)                                       err_d = ERR_OVERFLOW;
        else begin
          wr_en   = 1'b1;
          cnt_d   = port.in_data;
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (!port.in_valid) err_d = ERR_TRUNC;
        else if (full)      err_d = ERR_OVERFLOW;
        else begin
          wr_en        = 1'b1;
          wr_entry.eop = (cnt_q == 8'd1);
          if (cnt_q == 8'd1) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_DROP: begin
        if (!port.in_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (err_d != ERR_NONE) begin
      rollback = 1'b1;
      state_d  = (err_d == ERR_TRUNC) ? ST_IDLE : ST_DROP;
    end

    err_pulse_d = (err_d != ERR_NONE);
    pkt_cnt_d   = (commit && pkt_cnt_q != '1) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    err_cnt_d   = (err_pulse_d && err_cnt_q != '1) ? err_cnt_q + 16'd1 : err_cnt_q;
    suspend_d   = (free < Margin);
    sop_d       = rd_en ? rd_entry.eop : sop_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      suspend_q   <= 1'b0;
      sop_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      suspend_q   <= suspend_d;
      sop_q       <= sop_d;
    end
  end

  assign rd_en          = rd_valid && port.out_ready;
  assign port.out_valid = rd_valid;
  assign port.out_data  = rd_valid ? rd_entry.data : '0;
  assign port.out_eop   = rd_valid & rd_entry.eop;
  assign port.out_sop   = rd_valid & sop_q;
  assign port.out_ptype = (rd_valid & sop_q) ? classify_ptype(rd_entry.data[3:0]) : PT_SINGLE;
  assign port.suspend_o = suspend_q;

  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_switch_port_rx.sv
// Directed bench for switch_port_rx (PORT_ID=1) with byte and error scoreboards.
module tb_switch_port_rx;

  typedef logic [7:0]  bytes_t[$];
  typedef logic [11:0] exp_t;   // {sop, eop, ptype, data}

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [15:0] pkt_cnt, err_cnt;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t exp_q[$];
  logic [2:0] err_q[$];

  switch_port_rx_if bus ();

  switch_port_rx #(
    .PORT_ID(1), .FIFO_DEPTH(64), .MAX_LEN(32), .SUSPEND_MARGIN(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .port      (bus),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
  endtask

  function automatic logic [1:0] exp_ptype(input logic [3:0] t);
    if (t == 4'hf) return 2'd2;
    if (t == 4'h1 || t == 4'h2 || t == 4'h4 || t == 4'h8) return 2'd0;
    return 2'd1;
  endfunction

  function automatic bytes_t rand_pay(input int n);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic drive(input logic [7:0] b);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] len,
                          input bytes_t pay, input bit good);
    if (good) begin
      exp_q.push_back({1'b1, 1'b0, exp_ptype(hdr[3:0]), hdr});
      exp_q.push_back({4'b0000, len});
      foreach (pay[i]) exp_q.push_back({1'b0, (i == pay.size() - 1), 2'b00, pay[i]});
    end
    drive(hdr);
    drive(len);
    foreach (pay[i]) drive(pay[i]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    chk(tag, done, 1);
  endtask

  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      chk("byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        chk("out_byte", {bus.out_sop, bus.out_eop, (bus.out_sop ? bus.out_ptype : 2'b00), bus.out_data},
            exp_q.pop_front());
    end
    if (reset && err_pulse) begin
      chk("err_expected", err_q.size() != 0, 1);
      if (err_q.size() != 0) chk("err_code", err_code, err_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bytes_t p;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_suspend", bus.suspend_o, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    reset = 1'b1;

    // single packet, latency: header visible the cycle after the last byte
    p.delete();
    p.push_back(8'hAA); p.push_back(8'hBB); p.push_back(8'hCC);
    send_pkt(8'h12, 8'd3, p, 1'b1);
    @(negedge clk);
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_hdr", bus.out_data, 8'h12);
    wait_drain("drain_single");
    chk("pkt_cnt_1", pkt_cnt, 1);

    // broadcast with source/target overlap
    send_pkt(8'h4F, 8'd1, rand_pay(1), 1'b1);
    wait_drain("drain_bcast");
    chk("pkt_cnt_2", pkt_cnt, 2);

    // header errors
    err_q.push_back(3'd1); send_pkt(8'h32, 8'd2, rand_pay(2), 1'b0);
    err_q.push_back(3'd2); send_pkt(8'h21, 8'd2, rand_pay(2), 1'b0);
    err_q.push_back(3'd3); send_pkt(8'h23, 8'd2, rand_pay(2), 1'b0);
    repeat (3) @(negedge clk);
    chk("hdr_err_cnt", err_cnt, 3);
    chk("hdr_no_out", bus.out_valid, 0);
    chk("hdr_err_seen", err_q.size(), 0);

    // zero length, then a good packet straight after
    err_q.push_back(3'd4); send_pkt(8'h12, 8'd0, rand_pay(3), 1'b0);
    send_pkt(8'h12, 8'd2, rand_pay(2), 1'b1);
    wait_drain("drain_after_len0");
    chk("len0_pkt_cnt", pkt_cnt, 3);
    chk("len0_err_cnt", err_cnt, 4);

    // truncated after 2 of 5 payload bytes
    err_q.push_back(3'd5); send_pkt(8'h12, 8'd5, rand_pay(2), 1'b0);
    repeat (3) @(negedge clk);
    chk("trunc_err_cnt", err_cnt, 5);
    chk("trunc_pkt_cnt", pkt_cnt, 3);
    chk("trunc_no_out", bus.out_valid, 0);

    // backpressure: 32 + 30 entries leave 2 free, next packet overflows
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_pkt(8'h82, 8'd30, rand_pay(30), 1'b1);
    repeat (3) @(negedge clk);
    chk("half_suspend", bus.suspend_o, 0);
    chk("stall_hdr", bus.out_data, 8'h82);
    chk("stall_sop", bus.out_sop, 1);
    send_pkt(8'h1E, 8'd28, rand_pay(28), 1'b1);
    repeat (3) @(negedge clk);
    chk("full_suspend", bus.suspend_o, 1);
    chk("stall_stable", bus.out_data, 8'h82);
    err_q.push_back(3'd6); send_pkt(8'h12, 8'd5, rand_pay(5), 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf_err_cnt", err_cnt, 6);
    chk("ovf_pkt_cnt", pkt_cnt, 5);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain("drain_backpressure");
    repeat (2) @(negedge clk);
    chk("drained_suspend", bus.suspend_o, 0);

    // reset in the middle of a payload with a committed packet waiting
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_pkt(8'h12, 8'd2, rand_pay(2), 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", bus.out_valid, 1);
    drive(8'h12); drive(8'd6); drive(8'h01); drive(8'h02); drive(8'h03);
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_sop", bus.out_sop, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_suspend", bus.suspend_o, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send_pkt(8'h12, 8'd4, rand_pay(4), 1'b1);
    wait_drain("drain_after_reset");
    chk("post_rst_pkt_cnt", pkt_cnt, 1);
    chk("post_rst_err_cnt", err_cnt, 0);

    chk("sb_empty", exp_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
